// File: rtl/wino_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) output path:
// pixel width, 2x2 tile packing offsets and element extraction.
package wino_pkg;

    localparam int WO  = 32;

    // Element slot within a packed tile word: yRC sits at slot 2*R + C.
    localparam int Y00 = 0;
    localparam int Y01 = 1;
    localparam int Y10 = 2;
    localparam int Y11 = 3;

    function automatic logic [WO-1:0] tile_elem(input logic [4*WO-1:0] tile,
                                                 input logic            r,
                                                 input logic            c);
        logic [WO-1:0] e;
        case ({r, c})
            2'b00:   e = tile[Y00*WO +: WO];
            2'b01:   e = tile[Y01*WO +: WO];
            2'b10:   e = tile[Y10*WO +: WO];
            2'b11:   e = tile[Y11*WO +: WO];
            default: e = tile[Y00*WO +: WO];
        endcase
        return e;
    endfunction

endpackage

// File: rtl/wino_out_raster_if.sv
// Tile-in / pixel-out handshake bundle of wino_out_raster.
interface wino_out_raster_if;
    import wino_pkg::*;

    logic              tile_valid;
    logic              tile_ready;
    logic [4*WO-1:0]   tile_y;
    logic              out_valid;
    logic              out_ready;
    logic [WO-1:0]     out_data;
    logic              out_sol;
    logic              out_eol;
    logic              out_eof;

    modport slave (
        input  tile_valid, tile_y, out_ready,
        output tile_ready, out_valid, out_data, out_sol, out_eol, out_eof
    );

    modport master (
        output tile_valid, tile_y, out_ready,
        input  tile_ready, out_valid, out_data, out_sol, out_eol, out_eof
    );

endinterface

// File: rtl/wino_tile_bank.sv
// One tile-row buffer: TW packed 2x2 tiles in flops, single write port,
// combinational read port.
module wino_tile_bank
    import wino_pkg::*;
#(
    parameter int TW = 4,
    parameter int AW = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [4*WO-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [4*WO-1:0] rdata
);

    logic [4*WO-1:0] mem_r [TW];

    // Tile storage, cleared on reset so discarded rows never reappear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TW; i++) begin
                mem_r[i] <= {(4*WO){1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/wino_out_raster.sv
// Re-serialises 2x2 tiles (tile-raster order) into a pixel raster stream
// through a ping-pong pair of tile-row banks. TW must be a power of two.
module wino_out_raster
    import wino_pkg::*;
#(
    parameter int TW = 4,
    parameter int TH = 2
) (
    input  logic               clk,
    input  logic               rstn,
    wino_out_raster_if.slave   bus
);

    localparam int AW     = (TW > 1) ? $clog2(TW) : 1;
    localparam int CW     = AW + 1;
    localparam int RW     = (TH > 1) ? $clog2(TH) : 1;
    localparam int C_LAST = 2 * TW - 1;

    logic [1:0]      full_r;
    logic            wbank_r;
    logic            rbank_r;
    logic [AW-1:0]   wcol_r;
    logic [CW-1:0]   c_r;
    logic            r_r;
    logic [RW-1:0]   trow_r;

    logic            tile_acc_s;
    logic            pix_acc_s;
    logic            line_end_s;
    logic            row_done_s;
    logic            drain_done_s;
    logic [1:0]      full_nxt_s;
    logic [4*WO-1:0] rdata0_s;
    logic [4*WO-1:0] rdata1_s;
    logic [4*WO-1:0] tile_sel_s;
    logic [WO-1:0]   elem_s;

    assign bus.tile_ready = !full_r[wbank_r];
    assign bus.out_valid  = full_r[rbank_r];

    assign tile_acc_s   = bus.tile_valid && bus.tile_ready;
    assign pix_acc_s    = bus.out_valid && bus.out_ready;
    assign line_end_s   = (c_r == CW'(C_LAST));
    assign row_done_s   = tile_acc_s && (wcol_r == AW'(TW - 1));
    assign drain_done_s = pix_acc_s && line_end_s && r_r;

    wino_tile_bank #(.TW(TW), .AW(AW)) u_bank0 (
        .clk   (clk),
        .rstn  (rstn),
        .we    (tile_acc_s && !wbank_r),
        .waddr (wcol_r),
        .wdata (bus.tile_y),
        .raddr (c_r[CW-1:1]),
        .rdata (rdata0_s)
    );

    wino_tile_bank #(.TW(TW), .AW(AW)) u_bank1 (
        .clk   (clk),
        .rstn  (rstn),
        .we    (tile_acc_s && wbank_r),
        .waddr (wcol_r),
        .wdata (bus.tile_y),
        .raddr (c_r[CW-1:1]),
        .rdata (rdata1_s)
    );

    // Set and clear never hit the same bank together: a write needs a
    // non-full bank, a drain needs a full one.
    always_comb begin
        full_nxt_s          = full_r;
        full_nxt_s[wbank_r] = full_r[wbank_r] | row_done_s;
        full_nxt_s[rbank_r] = full_nxt_s[rbank_r] & ~drain_done_s;
    end

    // Pixel selection: line r picks tile row r, c[0] picks the tile column.
    always_comb begin
        tile_sel_s = rbank_r ? rdata1_s : rdata0_s;
        elem_s     = tile_elem(tile_sel_s, r_r, c_r[0]);
    end

    assign bus.out_data = bus.out_valid ? elem_s : {WO{1'b0}};
    assign bus.out_sol  = bus.out_valid && (c_r == CW'(0));
    assign bus.out_eol  = bus.out_valid && line_end_s;
    assign bus.out_eof  = bus.out_valid && line_end_s && r_r && (trow_r == RW'(TH - 1));

    // Write/read pointers, bank flags and frame position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_r  <= 2'b00;
            wbank_r <= 1'b0;
            rbank_r <= 1'b0;
            wcol_r  <= AW'(0);
            c_r     <= CW'(0);
            r_r     <= 1'b0;
            trow_r  <= RW'(0);
        end else begin
            full_r <= full_nxt_s;
            if (tile_acc_s) begin
                if (row_done_s) begin
                    wcol_r  <= AW'(0);
                    wbank_r <= ~wbank_r;
                end else begin
                    wcol_r  <= wcol_r + AW'(1);
                end
            end
            if (pix_acc_s) begin
                if (line_end_s) begin
                    c_r <= CW'(0);
                    r_r <= ~r_r;
                    if (r_r) begin
                        rbank_r <= ~rbank_r;
                        trow_r  <= (trow_r == RW'(TH - 1)) ? RW'(0) : trow_r + RW'(1);
                    end
                end else begin
                    c_r <= c_r + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wino_out_raster.sv
// Directed bench for wino_out_raster (TW=4, TH=2): raster order, markers,
// backpressure, reset mid-drain and random output stalls.
module tb_wino_out_raster;
    import wino_pkg::*;

    localparam int TW = 4;
    localparam int TH = 2;
    localparam int FP = 4 * TW * TH;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wino_out_raster_if bus ();

    wino_out_raster #(.TW(TW), .TH(TH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [7:0] exp_basic [16] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23,
                                   8'h30, 8'h40, 8'h31, 8'h41, 8'h32, 8'h42, 8'h33, 8'h43};

    function automatic logic [4*WO-1:0] mk(input int i);
        return {WO'(32'h40 + i), WO'(32'h30 + i), WO'(32'h20 + i), WO'(32'h10 + i)};
    endfunction

    function automatic logic [WO-1:0] pv(input int n, input int r, input int c);
        return 32'hA000_0000 | WO'(n << 8) | WO'(r << 4) | WO'(c);
    endfunction

    function automatic logic [4*WO-1:0] tile_of(input int n);
        return {pv(n, 1, 1), pv(n, 1, 0), pv(n, 0, 1), pv(n, 0, 0)};
    endfunction

    // Raster model: pixel p of the stream fed with tile_of(0), tile_of(1), ...
    function automatic logic [WO-1:0] exp_px(input int p);
        int q, tr, n, r, col;
        q   = p % FP;
        tr  = q / (4 * TW);
        r   = (q % (4 * TW)) / (2 * TW);
        col = q % 2;
        n   = (p / FP) * (TW * TH) + tr * TW + (q % (2 * TW)) / 2;
        return pv(n, r, col);
    endfunction

    task automatic cycle(output logic px, output logic [WO-1:0] d, output logic sol,
                         output logic eol, output logic eof, output logic acc);
        px  = bus.out_valid && bus.out_ready;
        d   = bus.out_data;
        sol = bus.out_sol;
        eol = bus.out_eol;
        eof = bus.out_eof;
        acc = bus.tile_valid && bus.tile_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        bus.tile_valid = 1'b0;
        bus.tile_y     = '0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn           = 1'b1;
        bus.tile_valid = 1'b0;
        bus.tile_y     = '0;
        bus.out_ready  = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.tile_ready !== 1'b1) begin
            errors++; $display("FAIL reset_tile_ready got %b exp 1", bus.tile_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0 || {bus.out_sol, bus.out_eol, bus.out_eof} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs got d=%h m=%b exp 0", bus.out_data,
                               {bus.out_sol, bus.out_eol, bus.out_eof});
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tile_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++; $display("FAIL idle_after_reset got rdy=%b v=%b d=%h exp 1 0 0",
                               bus.tile_ready, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_basic();
        logic px, sol, eol, eof, acc, lat_chk;
        logic [WO-1:0] d;
        int n, p;
        do_reset();
        bus.out_ready  = 1'b1;
        bus.tile_valid = 1'b1;
        bus.tile_y     = mk(0);
        n = 0; p = 0; lat_chk = 1'b0;
        for (int cyc = 0; cyc < 60 && p < 16; cyc++) begin
            if (lat_chk) begin
                lat_chk = 1'b0;
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL basic_latency got out_valid=%b exp 1", bus.out_valid);
                end
            end
            cycle(px, d, sol, eol, eof, acc);
            if (acc) begin
                n++;
                if (n == TW) begin
                    bus.tile_valid = 1'b0;
                    lat_chk = 1'b1;
                end else begin
                    bus.tile_y = mk(n);
                end
            end
            if (px) begin
                checks++;
                if (d !== WO'(exp_basic[p]) || sol !== (p % 8 == 0) || eol !== (p % 8 == 7) || eof !== 1'b0) begin
                    errors++; $display("FAIL basic_px p=%0d got d=%h s/e/f=%b%b%b exp d=%h s/e/f=%b%b0",
                                       p, d, sol, eol, eof, WO'(exp_basic[p]), p % 8 == 0, p % 8 == 7);
                end
                p++;
            end
        end
        checks++;
        if (p != 16) begin
            errors++; $display("FAIL basic_count got %0d pixels exp 16", p);
        end
    endtask

    task automatic test_backpressure();
        logic px, sol, eol, eof, acc, stable_ok;
        logic [WO-1:0] d;
        int n;
        do_reset();
        bus.out_ready  = 1'b0;
        bus.tile_valid = 1'b1;
        bus.tile_y     = tile_of(0);
        n = 0; stable_ok = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            cycle(px, d, sol, eol, eof, acc);
            if (acc) begin
                n++;
                bus.tile_y = tile_of(n);
            end
            if (bus.out_valid && (bus.out_data !== exp_px(0) || bus.out_sol !== 1'b1))
                stable_ok = 1'b0;
        end
        checks++;
        if (n != 2 * TW) begin
            errors++; $display("FAIL bp_accepted got %0d tiles exp %0d", n, 2 * TW);
        end
        checks++;
        if (bus.tile_ready !== 1'b0) begin
            errors++; $display("FAIL bp_tile_ready got %b exp 0", bus.tile_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || stable_ok !== 1'b1) begin
            errors++; $display("FAIL bp_hold got v=%b stable=%b exp 1 1", bus.out_valid, stable_ok);
        end
        bus.tile_valid = 1'b0;
        bus.out_ready  = 1'b1;
        for (int p = 0; p < 2 * FP / TH; p++) begin
            if (p == 15 || p == 16) begin
                checks++;
                if (bus.tile_ready !== (p == 16)) begin
                    errors++; $display("FAIL bp_ready_return p=%0d got %b exp %b", p, bus.tile_ready, p == 16);
                end
            end
            cycle(px, d, sol, eol, eof, acc);
            checks++;
            if (px !== 1'b1 || d !== exp_px(p) || sol !== (p % 8 == 0) || eol !== (p % 8 == 7) ||
                eof !== (p == 31)) begin
                errors++; $display("FAIL bp_drain p=%0d got v=%b d=%h s/e/f=%b%b%b exp 1 d=%h s/e/f=%b%b%b",
                                   p, px, d, sol, eol, eof, exp_px(p), p % 8 == 0, p % 8 == 7, p == 31);
            end
        end
    endtask

    task automatic test_frame();
        logic px, sol, eol, eof, acc;
        logic [WO-1:0] d;
        int n, p, eof_cnt;
        do_reset();
        bus.out_ready  = 1'b1;
        bus.tile_valid = 1'b1;
        bus.tile_y     = tile_of(0);
        n = 0; p = 0; eof_cnt = 0;
        for (int cyc = 0; cyc < 300 && p < 48; cyc++) begin
            cycle(px, d, sol, eol, eof, acc);
            if (acc) begin
                n++;
                if (n == 12) bus.tile_valid = 1'b0;
                else         bus.tile_y = tile_of(n);
            end
            if (px) begin
                if (eof) eof_cnt++;
                checks++;
                if (d !== exp_px(p) || sol !== (p % 8 == 0) || eol !== (p % 8 == 7) || eof !== (p % FP == FP - 1)) begin
                    errors++; $display("FAIL frame_px p=%0d got d=%h s/e/f=%b%b%b exp d=%h s/e/f=%b%b%b",
                                       p, d, sol, eol, eof, exp_px(p), p % 8 == 0, p % 8 == 7, p % FP == FP - 1);
                end
                p++;
            end
        end
        checks++;
        if (p != 48 || eof_cnt != 1) begin
            errors++; $display("FAIL frame_count got %0d pixels %0d eof exp 48 1", p, eof_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic px, sol, eol, eof, acc;
        logic [WO-1:0] d;
        int n, p;
        do_reset();
        bus.tile_valid = 1'b1;
        bus.tile_y     = tile_of(0);
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
            cycle(px, d, sol, eol, eof, acc);
            if (acc) begin
                n++;
                bus.tile_y = tile_of(n);
            end
        end
        bus.tile_valid = 1'b0;
        bus.out_ready  = 1'b1;
        p = 0;
        for (int cyc = 0; cyc < 10 && p < 3; cyc++) begin
            cycle(px, d, sol, eol, eof, acc);
            if (px) p++;
        end
        checks++;
        if (n != 6 || p != 3 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup got tiles=%0d px=%0d v=%b exp 6 3 1", n, p, bus.out_valid);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || {bus.out_sol, bus.out_eol, bus.out_eof} !== 3'b000 ||
            bus.tile_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got v=%b d=%h m=%b rdy=%b exp 0 0 000 1", bus.out_valid,
                               bus.out_data, {bus.out_sol, bus.out_eol, bus.out_eof}, bus.tile_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.tile_valid = 1'b1;
        bus.tile_y     = mk(0);
        n = 0; p = 0;
        for (int cyc = 0; cyc < 40 && p < 8; cyc++) begin
            cycle(px, d, sol, eol, eof, acc);
            if (acc) begin
                n++;
                if (n == TW) bus.tile_valid = 1'b0;
                else         bus.tile_y = mk(n);
            end
            if (px) begin
                checks++;
                if (d !== WO'(exp_basic[p]) || sol !== (p == 0) || eol !== (p == 7) || eof !== 1'b0) begin
                    errors++; $display("FAIL mid_restart p=%0d got d=%h s/e/f=%b%b%b exp d=%h s/e/f=%b%b0",
                                       p, d, sol, eol, eof, WO'(exp_basic[p]), p == 0, p == 7);
                end
                p++;
            end
        end
        checks++;
        if (p != 8) begin
            errors++; $display("FAIL mid_restart_count got %0d exp 8", p);
        end
    endtask

    task automatic test_random();
        logic px, sol, eol, eof, acc, stall;
        logic [WO-1:0] d, prev_d;
        logic [2:0] prev_m;
        int n, p;
        do_reset();
        bus.tile_valid = 1'b1;
        bus.tile_y     = tile_of(0);
        bus.out_ready  = 1'($urandom_range(0, 1));
        n = 0; p = 0; stall = 1'b0;
        for (int cyc = 0; cyc < 3000 && p < 3 * FP; cyc++) begin
            if (stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_d ||
                    {bus.out_sol, bus.out_eol, bus.out_eof} !== prev_m) begin
                    errors++; $display("FAIL rand_protocol p=%0d got v=%b d=%h m=%b exp 1 d=%h m=%b", p,
                                       bus.out_valid, bus.out_data, {bus.out_sol, bus.out_eol, bus.out_eof},
                                       prev_d, prev_m);
                end
            end
            stall  = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_data;
            prev_m = {bus.out_sol, bus.out_eol, bus.out_eof};
            cycle(px, d, sol, eol, eof, acc);
            if (acc) begin
                n++;
                if (n == 3 * TW * TH) bus.tile_valid = 1'b0;
                else                  bus.tile_y = tile_of(n);
            end
            if (px) begin
                checks++;
                if (d !== exp_px(p) || sol !== (p % 8 == 0) || eol !== (p % 8 == 7) || eof !== (p % FP == FP - 1)) begin
                    errors++; $display("FAIL rand_px p=%0d got d=%h s/e/f=%b%b%b exp d=%h", p, d, sol, eol, eof,
                                       exp_px(p));
                end
                p++;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (p != 3 * FP) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", p, 3 * FP);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_frame();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
